// File: rtl/rf_pkg.sv
// Shared widths, state encoding and the registered write bundle for the
// register-file write-port arbiter.
package rf_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } rf_arb_state_t;

  typedef struct packed {
    logic              load;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, combinational from valids and pointer; zero latency.
// Holds both grants low when en is low; the pointer names the side not granted last.
module rr_arb2 (
  input  logic Clk,
  input  logic Reset,
  input  logic en,
  input  logic a_valid,
  input  logic b_valid,
  output logic a_grant,
  output logic b_grant
);

  logic prefer_b;

  assign a_grant = en && a_valid && (!b_valid || !prefer_b);
  assign b_grant = en && b_valid && (!a_valid || prefer_b);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      prefer_b <= 1'b0;
    end else if (a_grant) begin
      prefer_b <= 1'b1;
    end else if (b_grant) begin
      prefer_b <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between ALU (A) and load (B) writeback and
// sweeps zeroes on Clear_req; writes land one cycle after grant, readys drop during clear.
module rf_write_arbiter
  import rf_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              A_valid,
  output logic              A_ready,
  input  logic [ADDR_W-1:0] A_dest,
  input  logic [DATA_W-1:0] A_data,
  input  logic              B_valid,
  output logic              B_ready,
  input  logic [ADDR_W-1:0] B_dest,
  input  logic [DATA_W-1:0] B_data,
  input  logic              Clear_req,
  output logic              Clear_busy,
  output logic              RF_Load,
  output logic [ADDR_W-1:0] RF_Sel_Dest,
  output logic [DATA_W-1:0] RF_D_in
);

  rf_arb_state_t     state;
  logic [ADDR_W-1:0] cnt;
  rf_wr_t            wr_q;
  logic              arb_en;
  logic              a_gnt;
  logic              b_gnt;

  // A clear request pre-empts any grant in the cycle it arrives.
  assign arb_en = Reset && (state == ARB) && !Clear_req;

  rr_arb2 u_rr_arb2 (
    .Clk     (Clk),
    .Reset   (Reset),
    .en      (arb_en),
    .a_valid (A_valid),
    .b_valid (B_valid),
    .a_grant (a_gnt),
    .b_grant (b_gnt)
  );

  assign A_ready     = a_gnt;
  assign B_ready     = b_gnt;
  assign Clear_busy  = (state == CLEAR);
  assign RF_Load     = wr_q.load;
  assign RF_Sel_Dest = wr_q.dest;
  assign RF_D_in     = wr_q.data;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= ARB;
      cnt   <= '0;
      wr_q  <= '0;
    end else begin
      wr_q.load <= 1'b0;
      case (state)
        ARB: begin
          if (Clear_req) begin
            state <= CLEAR;
            cnt   <= '0;
          end else if (a_gnt) begin
            wr_q <= '{load: 1'b1, dest: A_dest, data: A_data};
          end else if (b_gnt) begin
            wr_q <= '{load: 1'b1, dest: B_dest, data: B_data};
          end
        end
        CLEAR: begin
          wr_q <= '{load: 1'b1, dest: cnt, data: '0};
          cnt  <= cnt + 1'b1;
          // Counter wraps to zero on the same edge the sweep exits.
          if (cnt == LAST_REG) begin
            state <= ARB;
          end
        end
        default: begin
          state <= ARB;
        end
      endcase
    end
  end

endmodule
